// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the iterative binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  function automatic int clog2(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/bin2bcd_seq_step.sv
// One double-dabble iteration: add-3 on every digit >=5, then shift in one bit.
module bcd_dabble_step
  import bin2bcd_pkg::*;
#(
  parameter int DIGITS = 5
) (
  input  logic [4*DIGITS-1:0] acc_i,
  input  logic                bit_i,
  output logic [4*DIGITS-1:0] acc_o,
  output logic                carry_o
);

  logic [4*DIGITS-1:0] adj;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    assign adj[4*g +: 4] = (acc_i[4*g +: 4] >= BCD_ADJ_THRESH) ?
                           acc_i[4*g +: 4] + BCD_ADJ_ADD : acc_i[4*g +: 4];
  end

  assign acc_o   = {adj[4*DIGITS-2:0], bit_i};
  assign carry_o = adj[4*DIGITS-1];

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter, one bit per clock, valid/ready on both sides.
// Define BIN2BCD_SIGNED_EN to treat the operand as two's complement.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIN_W-1:0]    binary,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] bcd,
  output logic                overflow,
  output logic                sign
);

  localparam int CNT_W = clog2(BIN_W);
  localparam int BCD_W = 4*DIGITS;

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   opnd_q, opnd_d;
  logic [BCD_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               sign_q, sign_d;

  logic [BCD_W-1:0]   step_acc;
  logic               step_carry;
  logic [BIN_W-1:0]   mag;
  logic               sgn;

  bcd_dabble_step #(.DIGITS(DIGITS)) u_step (
    .acc_i  (acc_q),
    .bit_i  (opnd_q[BIN_W-1]),
    .acc_o  (step_acc),
    .carry_o(step_carry)
  );

`ifdef BIN2BCD_SIGNED_EN
  // Magnitude of the most negative value wraps to 2^(BIN_W-1), still exact as unsigned.
  assign sgn = binary[BIN_W-1];
  assign mag = sgn ? (~binary + 1'b1) : binary;
`else
  assign sgn = 1'b0;
  assign mag = binary;
`endif

  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sign_d  = sign_q;
    case (state_q)
      IDLE: if (in_valid) begin
        opnd_d  = mag;
        sign_d  = sgn;
        acc_d   = '0;
        ovf_d   = 1'b0;
        cnt_d   = CNT_W'(BIN_W-1);
        state_d = SHIFT;
      end
      SHIFT: begin
        acc_d  = step_acc;
        opnd_d = {opnd_q[BIN_W-2:0], 1'b0};
        ovf_d  = ovf_q | step_carry;
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opnd_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sign_q  <= sign_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign bcd       = acc_q;
  assign overflow  = ovf_q;
  assign sign      = sign_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomised self-checking bench for bin2bcd_seq (5-digit and 4-digit instances).
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [13:0] binary = '0;
  logic        in_ready, out_valid, overflow, sign;
  logic [19:0] bcd;
  logic        in_ready4, out_valid4, overflow4, sign4;
  logic [15:0] bcd4;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(14), .DIGITS(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .binary(binary), .out_valid(out_valid), .out_ready(out_ready),
    .bcd(bcd), .overflow(overflow), .sign(sign)
  );

  bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .binary(binary), .out_valid(out_valid4), .out_ready(out_ready),
    .bcd(bcd4), .overflow(overflow4), .sign(sign4)
  );

  // Reference: decimal digits of the operand's value by plain arithmetic.
  function automatic void model(input logic [13:0] b, output logic [19:0] e5,
                                output logic [15:0] e4, output logic e4o,
                                output logic es);
    int v;
    int p;
`ifdef BIN2BCD_SIGNED_EN
    es = b[13];
    v  = b[13] ? 16384 - int'(b) : int'(b);
`else
    es = 1'b0;
    v  = int'(b);
`endif
    p  = 1;
    e5 = '0;
    for (int i = 0; i < 5; i++) begin
      e5[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    e4  = e5[15:0];
    e4o = (v > 9999);
  endfunction

  task automatic do_op(input logic [13:0] b, output int lat, output bit tmo);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    in_valid = 1'b1;
    binary   = b;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    tmo = !out_valid;
  endtask

  task automatic release_result;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || bcd !== 20'h0 || overflow !== 1'b0 || sign !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got ov=%b bcd=%h ovf=%b sign=%b rdy=%b want 0 0 0 0 0",
               out_valid, bcd, overflow, sign, in_ready);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic run_and_check(input string name, input logic [13:0] b);
    logic [19:0] e5; logic [15:0] e4; logic e4o, es;
    int lat; bit tmo;
    model(b, e5, e4, e4o, es);
    do_op(b, lat, tmo);
    vectors++;
    if (tmo || lat != 15) begin
      errors++;
      $display("FAIL %s_latency op=%0d: got %0d (timeout=%0b) want 15", name, b, lat, tmo);
    end
    vectors++;
    if (bcd !== e5 || overflow !== 1'b0 || sign !== es) begin
      errors++;
      $display("FAIL %s_d5 op=%h: got bcd=%h ovf=%b sign=%b want bcd=%h ovf=0 sign=%b",
               name, b, bcd, overflow, sign, e5, es);
    end
    vectors++;
    if (out_valid4 !== 1'b1 || bcd4 !== e4 || overflow4 !== e4o || sign4 !== es) begin
      errors++;
      $display("FAIL %s_d4 op=%h: got v=%b bcd=%h ovf=%b sign=%b want v=1 bcd=%h ovf=%b sign=%b",
               name, b, out_valid4, bcd4, overflow4, sign4, e4, e4o, es);
    end
    release_result();
  endtask

  task automatic test_directed;
    run_and_check("dir9999", 14'd9999);
    run_and_check("dirmax", 14'd16383);
    run_and_check("dirzero", 14'd0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 25; i++)
      run_and_check("rand", 14'($urandom_range(0, 16383)));
  endtask

  task automatic test_backpressure;
    logic [19:0] e5; logic [15:0] e4; logic e4o, es;
    int lat; bit tmo;
    model(14'd1234, e5, e4, e4o, es);
    do_op(14'd1234, lat, tmo);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      binary   = 14'd42;
      vectors++;
      if (tmo || out_valid !== 1'b1 || bcd !== e5 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc%0d: got v=%b bcd=%h rdy=%b want v=1 bcd=%h rdy=0",
                 i, out_valid, bcd, in_ready, e5);
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || bcd !== e5) begin
      errors++;
      $display("FAIL stall_ignored42: got v=%b rdy=%b bcd=%h want v=0 rdy=1 bcd=%h",
               out_valid, in_ready, bcd, e5);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    in_valid = 1'b1;
    binary   = 14'd4095;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || bcd !== 20'h0 || overflow !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got v=%b bcd=%h ovf=%b rdy=%b want 0 0 0 1",
               out_valid, bcd, overflow, in_ready);
    end
    run_and_check("after_rst", 14'd7);
  endtask

  task automatic test_back_to_back;
    logic [13:0] ops [6] = '{14'd0, 14'd1, 14'd9, 14'd10, 14'd99, 14'd100};
    logic [19:0] exp [6] = '{20'h0, 20'h1, 20'h9, 20'h10, 20'h99, 20'h100};
    int nxt = 0, got = 0, cyc = 0, last = 0;
    out_ready = 1'b1;
    @(negedge clk);
    while (got < 6 && cyc < 300) begin
      if (out_valid) begin
        vectors++;
        if (bcd !== exp[got] || overflow !== 1'b0) begin
          errors++;
          $display("FAIL b2b_result[%0d]: got bcd=%h ovf=%b want %h 0", got, bcd, overflow, exp[got]);
        end
        got++;
      end
      if (in_ready) begin
        if (nxt < 6) begin
          in_valid = 1'b1;
          binary   = ops[nxt];
          if (nxt > 0) begin
            vectors++;
            if (cyc - last != 16) begin
              errors++;
              $display("FAIL b2b_spacing[%0d]: got %0d want 16", nxt, cyc - last);
            end
          end
          last = cyc;
          nxt++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if (got != 6) begin
      errors++;
      $display("FAIL b2b_timeout: got %0d results want 6", got);
    end
  endtask

`ifdef BIN2BCD_SIGNED_EN
  task automatic test_signed;
    logic [13:0] ops [3] = '{14'h3FFF, 14'h2000, 14'h1FFF};
    logic [19:0] exp [3] = '{20'h00001, 20'h08192, 20'h08191};
    logic        sg  [3] = '{1'b1, 1'b1, 1'b0};
    int lat; bit tmo;
    for (int i = 0; i < 3; i++) begin
      do_op(ops[i], lat, tmo);
      vectors++;
      if (tmo || bcd !== exp[i] || sign !== sg[i] || overflow !== 1'b0) begin
        errors++;
        $display("FAIL signed[%0d]: got bcd=%h sign=%b ovf=%b want bcd=%h sign=%b ovf=0",
                 i, bcd, sign, overflow, exp[i], sg[i]);
      end
      release_result();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef BIN2BCD_SIGNED_EN
    test_signed();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
